// File: rtl/mestpro_program_sequencer.sv
// Program sequencer for the MestPro_V2 core: loadable program memory feeding the
// core's instruction bus with run/stop/step, N-pass looping, HALT and result capture.
module mestpro_program_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter logic [7:0]  HALT_OP = 8'hFF,
    parameter logic [7:0]  NOP_OP  = 8'h00,
    parameter int unsigned SETTLE  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic          start,
    input  logic          stop,
    input  logic          step,
    input  logic [7:0]    loop_cnt,
    input  logic [7:0]    out_data,
    output logic [7:0]    instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic [7:0]    pass_cnt,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    pass_q, pass_d;
    logic [7:0]    instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [7:0]    result_q, result_d;
    logic [3:0]    cnt_q, cnt_d;

    logic          issue;
    logic [AW-1:0] fetch_addr;
    logic [7:0]    fetch_op;
    logic [7:0]    pass_base;
    logic [8:0]    pass_next;
    logic          wrap;

    // A step out of IDLE always fetches from address 0 and starts a fresh pass count.
    assign fetch_addr = (state_q == StIdle) ? '0 : pc_q;
    assign pass_base  = (state_q == StIdle) ? 8'd0 : pass_q;
    assign fetch_op   = mem[fetch_addr];
    assign wrap       = (fetch_addr == AW'(DEPTH - 1));
    assign pass_next  = {1'b0, pass_base} + 9'd1;

    always_ff @(posedge clk) begin
        if (load_en && (state_q == StIdle)) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pass_d   = pass_q;
        instr_d  = NOP_OP;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;

        case (state_q)
            StIdle: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    pass_d  = 8'd0;
                end else if (step) begin
                    state_d = StPause;
                    pass_d  = 8'd0;
                    issue   = 1'b1;
                end
            end
            StRun: begin
                // HALT detection takes precedence over STOP.
                if (fetch_op == HALT_OP) begin
                    issue = 1'b1;
                end else if (stop) begin
                    state_d = StPause;
                end else begin
                    issue = 1'b1;
                end
            end
            StPause: begin
                if (stop) begin
                    state_d = StPause;
                end else if (start) begin
                    state_d = StRun;
                end else if (step) begin
                    issue = 1'b1;
                end
            end
            default: begin
                if (cnt_q == 4'(SETTLE - 1)) begin
                    result_d = out_data;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        endcase

        if (issue) begin
            if (fetch_op == HALT_OP) begin
                state_d = StDrain;
                cnt_d   = 4'd0;
            end else begin
                instr_d = fetch_op;
                valid_d = 1'b1;
                pc_d    = fetch_addr + AW'(1);
                if (wrap) begin
                    pass_d = pass_next[8] ? 8'hFF : pass_next[7:0];
                    if ((loop_cnt != 8'd0) && (pass_next == {1'b0, loop_cnt})) begin
                        state_d = StDrain;
                        cnt_d   = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            pass_q   <= 8'd0;
            instr_q  <= NOP_OP;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pass_q   <= pass_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pass_cnt    = pass_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign result      = result_q;

endmodule

// File: tb/tb_mestpro_program_sequencer.sv
// Directed bench for mestpro_program_sequencer: HALT/drain, looping, stop/resume,
// stepping, load-while-busy and asynchronous reset.
module tb_mestpro_program_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic       stop;
    logic       step;
    logic [7:0] loop_cnt;
    logic [7:0] out_data;
    logic [7:0] instruction;
    logic       instr_valid;
    logic [3:0] pc;
    logic [7:0] pass_cnt;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    mestpro_program_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .loop_cnt    (loop_cnt),
        .out_data    (out_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pass_cnt    (pass_cnt),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    initial begin
        int n_valid;
        int n_done;
        int seq_err;
        int wrap_seen;
        int pass_at_done;

        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        stop      = 1'b0;
        step      = 1'b0;
        loop_cnt  = 8'd0;
        out_data  = 8'hA5;
        #12;
        check_eq("rst_instr", instruction, 8'h00);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_pc", pc, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: short program ending in HALT
        load(4'd0, 8'h11);
        load(4'd1, 8'h22);
        load(4'd2, 8'hFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t1_busy", busy, 1);
        check_eq("t1_valid0", instr_valid, 0);
        tick();
        check_eq("t1_instr0", instruction, 8'h11);
        check_eq("t1_valid1", instr_valid, 1);
        tick();
        check_eq("t1_instr1", instruction, 8'h22);
        tick();
        check_eq("t1_halt_nop", instruction, 8'h00);
        check_eq("t1_halt_valid", instr_valid, 0);
        check_eq("t1_halt_pc", pc, 2);
        tick();
        tick();
        check_eq("t1_done_early", done, 0);
        tick();
        check_eq("t1_done", done, 1);
        check_eq("t1_result", result, 8'hA5);
        check_eq("t1_busy_low", busy, 0);
        tick();
        check_eq("t1_done_pulse", done, 0);

        // Test 2: full memory, no HALT, two passes
        for (int i = 0; i < 16; i++) load(4'(i), 8'(8'h30 + i));
        loop_cnt = 8'd2;
        out_data = 8'h5C;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_valid = 0;
        n_done = 0;
        seq_err = 0;
        wrap_seen = 0;
        pass_at_done = -1;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            tick();
            if (instr_valid) begin
                if (int'(instruction) != 'h30 + (n_valid % 16)) seq_err++;
                if (instruction == 8'h3F && pc == 4'd0) wrap_seen = 1;
                n_valid++;
            end
            if (done) begin
                n_done++;
                pass_at_done = pass_cnt;
            end
        end
        tick();
        if (done) n_done++;
        check_eq("t2_valid_count", n_valid, 32);
        check_eq("t2_sequence", seq_err, 0);
        check_eq("t2_pc_wrap", wrap_seen, 1);
        check_eq("t2_pass_cnt", pass_at_done, 2);
        check_eq("t2_done_count", n_done, 1);
        check_eq("t2_result", result, 8'h5C);

        // Test 3: stop at PC=5, resume
        loop_cnt = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("t3_pc5", pc, 5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("t3_stop_valid", instr_valid, 0);
        check_eq("t3_stop_pc", pc, 5);
        tick();
        check_eq("t3_pause_pc", pc, 5);
        check_eq("t3_pause_busy", busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t3_resume_instr", instruction, 8'h35);
        check_eq("t3_resume_pc", pc, 6);

        // Test 5: START+STOP together pauses; load while busy is dropped
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("t5_both_valid", instr_valid, 0);
        check_eq("t5_both_pc", pc, 6);
        tick();
        check_eq("t5_still_paused", instr_valid, 0);
        load(4'd6, 8'h99);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t5_mem_unchanged", instruction, 8'h36);

        // Test 6: asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_instr", instruction, 8'h00);
        check_eq("t6_valid", instr_valid, 0);
        check_eq("t6_pc", pc, 0);
        check_eq("t6_pass", pass_cnt, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_result", result, 0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();

        // Test 4: three steps from IDLE
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            check_eq($sformatf("t4_step%0d_instr", k), instruction, 'h30 + k);
            check_eq($sformatf("t4_step%0d_valid", k), instr_valid, 1);
            tick();
            check_eq($sformatf("t4_step%0d_nop", k), instr_valid, 0);
        end
        check_eq("t4_pc", pc, 3);
        check_eq("t4_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
